// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous master for a single-port SRAM with active-low
// cs/oe/we, a shared tri-state data bus and registered read data.
// Turns a valid/ready request stream into SRAM cycles and returns read
// data on a valid/ready response channel.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data, held while rsp_valid is high
//   sram_cs/oe/we         SRAM controls, active low
//   sram_addr             SRAM address, registered
//   sram_data             SRAM data bus, driven only in the WRITE state
module sram_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRd1,
    StRd2,
    StResp
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_rsp_valid;
  logic          w_accept;
  logic          w_drive;
  logic          w_cs;
  logic          w_oe;
  logic          w_we;

  assign w_accept = req_valid && (r_state == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // The SRAM drives its registered data during RD2; capture at its end.
      if (r_state == StRd2) begin
        r_rdata     <= sram_data;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == StResp) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Controls are decoded from the state register only, never from req_*.
  always_comb begin
    w_state_next = r_state;
    w_cs         = 1'b1;
    w_oe         = 1'b1;
    w_we         = 1'b1;
    w_drive      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = req_we ? StWrite : StRd1;
        end
      end
      StWrite: begin
        w_cs         = 1'b0;
        w_we         = 1'b0;
        w_drive      = 1'b1;
        w_state_next = StIdle;
      end
      StRd1: begin
        w_cs         = 1'b0;
        w_oe         = 1'b0;
        w_state_next = StRd2;
      end
      StRd2: begin
        w_cs         = 1'b0;
        w_oe         = 1'b0;
        w_state_next = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign sram_cs   = w_cs;
  assign sram_oe   = w_oe;
  assign sram_we   = w_we;
  assign sram_addr = r_addr;
  assign sram_data = w_drive ? r_wdata : {DW{1'bz}};

endmodule
